// File: rtl/sync_fifo_pkg.sv
// Shared defaults and sizing helpers for the parametrised single-clock FIFO.
package sync_fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

  // One extra bit so occupancy can represent DEPTH itself.
  function automatic int count_w_of(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_W simple dual-port RAM: sync write, registered read-first read (1 clk).
// No backpressure; the caller gates wr_en/rd_en. Only the read register is reset.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Non-blocking read of the same address returns the pre-write entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO, 1-clk read latency with rd_valid strobe; writes refused when full unless a
// read is accepted in the same cycle. SYNC_FIFO_ERR_EN enables sticky overflow/underflow flags.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = depth_of(ADDR_W);
  localparam int CNT_W = count_w_of(ADDR_W);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              rd_acc;
  logic              wr_acc;

  assign empty        = (count == '0);
  assign full         = (count == CNT_W'(DEPTH));
  assign almost_full  = (count >= CNT_W'(AF_THRESH));
  assign almost_empty = (count <= CNT_W'(AE_THRESH));

  // No bypass: a read on an empty FIFO is refused even when a write lands that cycle.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en & ~wr_acc) begin
        overflow <= 1'b1;
      end
      if (rd_en & ~rd_acc) begin
        underflow <= 1'b1;
      end
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param at default parameters (8 bits x 8 entries, AF=6, AE=2).
module tb_sync_fifo_param;

`ifdef SYNC_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] count;
  logic       overflow;
  logic       underflow;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  sync_fifo_param dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       rd;
    logic [3:0] cnt;
    logic       fl;
    logic       em;
    logic       af;
    logic       ae;
    logic       vld;
    logic [7:0] dat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs, let one rising edge pass, return 1 time unit after it.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic w, input logic [7:0] d, input logic r,
                              input logic [3:0] c, input logic v, input logic [7:0] q);
    vec_t t;
    t.wr = w; t.wd = d; t.rd = r; t.cnt = c;
    t.fl = (c == 4'd8); t.em = (c == 4'd0);
    t.af = (c >= 4'd6); t.ae = (c <= 4'd2);
    t.vld = v; t.dat = q;
    return t;
  endfunction

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_d;
    logic       w, r, racc, wacc;
    logic [7:0] nxt;

    // Fill, overfill, drain, underread, empty write+read, read back.
    for (int i = 0; i < 8; i++) vecs.push_back(mk(1, 8'h10 + 8'(i), 0, 4'(i + 1), 0, 8'h00));
    vecs.push_back(mk(1, 8'h99, 0, 4'd8, 0, 8'h00));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 8'h00, 1, 4'(7 - i), 1, 8'h10 + 8'(i)));
    vecs.push_back(mk(0, 8'h00, 1, 4'd0, 0, 8'h17));
    vecs.push_back(mk(1, 8'h55, 1, 4'd1, 0, 8'h17));
    vecs.push_back(mk(0, 8'h00, 1, 4'd0, 1, 8'h55));

    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", count, 0);
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    chk("reset_ae", almost_empty, 1);
    chk("reset_af", almost_full, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_underflow", underflow, 0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].wr, vecs[i].wd, vecs[i].rd);
      chk($sformatf("v%0d_count", i), count, vecs[i].cnt);
      chk($sformatf("v%0d_full", i), full, vecs[i].fl);
      chk($sformatf("v%0d_empty", i), empty, vecs[i].em);
      chk($sformatf("v%0d_af", i), almost_full, vecs[i].af);
      chk($sformatf("v%0d_ae", i), almost_empty, vecs[i].ae);
      chk($sformatf("v%0d_rd_valid", i), rd_valid, vecs[i].vld);
      chk($sformatf("v%0d_rd_data", i), rd_data, vecs[i].dat);
      if (i == 8) chk("overflow_after_9th_write", overflow, ERR_EN);
      if (i == 17) chk("underflow_after_empty_read", underflow, ERR_EN);
    end

    // Full FIFO with simultaneous write+read: read-first, count holds at DEPTH.
    for (int i = 0; i < 8; i++) step(1, 8'h20 + 8'(i), 0);
    chk("full_before_wr_rd", full, 1);
    step(1, 8'hAA, 1);
    chk("full_wr_rd_data", rd_data, 8'h20);
    chk("full_wr_rd_valid", rd_valid, 1);
    chk("full_wr_rd_count", count, 8);
    for (int i = 0; i < 8; i++) begin
      step(0, 8'h00, 1);
      exp_d = (i == 7) ? 8'hAA : 8'h21 + 8'(i);
      chk($sformatf("drain%0d_data", i), rd_data, exp_d);
      chk($sformatf("drain%0d_count", i), count, 4'(7 - i));
    end
    chk("drain_empty", empty, 1);

    // Interleaved traffic against a queue model; pointers move well past the wrap.
    nxt = 8'h60;
    for (int i = 0; i < 20; i++) begin
      w = (i % 4) != 3;
      r = (i % 3) != 0;
      racc = r && (q.size() != 0);
      wacc = w && ((q.size() < 8) || racc);
      exp_d = 8'h00;
      if (racc) exp_d = q.pop_front();
      if (wacc) q.push_back(nxt);
      step(w, nxt, r);
      nxt = nxt + 8'd1;
      chk($sformatf("mix%0d_valid", i), rd_valid, racc);
      if (racc) chk($sformatf("mix%0d_data", i), rd_data, exp_d);
      chk($sformatf("mix%0d_count", i), count, 4'(q.size()));
    end
    while (q.size() != 0) begin
      exp_d = q.pop_front();
      step(0, 8'h00, 1);
      chk("mix_tail_data", rd_data, exp_d);
    end
    chk("mix_tail_empty", empty, 1);

    // Async reset mid-burst at count 5, observed before the next clock edge.
    for (int i = 0; i < 6; i++) step(1, 8'hC0 + 8'(i), 0);
    step(0, 8'h00, 1);
    chk("pre_rst_count", count, 5);
    chk("pre_rst_data", rd_data, 8'hC0);
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_empty", empty, 1);
    chk("async_rst_rd_data", rd_data, 0);
    chk("async_rst_rd_valid", rd_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1, 8'h77, 0);
    step(0, 8'h00, 1);
    chk("post_rst_data", rd_data, 8'h77);
    chk("post_rst_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
